// File: rtl/uart_loader_pkg.sv
// Shared types for the UART boot-image loader: FSM encoding and little-endian byte placement.
// Combinational helpers only; no latency, no flow control.
// Imported by the loader top and its byte FIFO.
package uart_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Drop one byte into lane idx of a little-endian word.
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  data);
        logic [31:0] r;
        r = word;
        case (idx)
            2'd0:    r[7:0]   = data;
            2'd1:    r[15:8]  = data;
            2'd2:    r[23:16] = data;
            default: r[31:24] = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO, first-word-fall-through: head byte readable while empty is low.
// Latency: a pushed byte is visible at the head one cycle later.
// Backpressure: none upstream; a push while full (and no pop) is dropped and pulses overflow.
module uart_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so push-while-full is only lost without one.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_word_loader.sv
// Boot-image loader: 4-byte LE word count N, then N LE words written to BASE_ADDR + 4*i.
// Latency: min 5 cycles per word (4 byte pops + 1 write handshake); FIFO adds 1 cycle.
// Backpressure: mem_ready stalls pops; bytes buffer in the FIFO, overflow sets sticky error.
import uart_loader_pkg::*;

module uart_word_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MAX_WORDS  = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t      state;
    logic [1:0]  byte_idx;
    logic [31:0] asm_word;
    logic [31:0] next_word;
    logic [31:0] count;
    logic [31:0] word_cnt;

    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_full_unused;
    logic        fifo_overflow;
    logic        pop;
    logic        last_byte;

    assign pop       = ((state == ST_LEN) || (state == ST_DATA)) && !fifo_empty;
    assign last_byte = (byte_idx == LAST_BYTE);
    assign next_word = put_byte(asm_word, byte_idx, fifo_data);

    uart_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (rx_data),
        .push     (rx_valid),
        .pop      (pop),
        .rd_data  (fifo_data),
        .full     (fifo_full_unused),
        .empty    (fifo_empty),
        .overflow (fifo_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LEN;
            byte_idx  <= 2'd0;
            asm_word  <= 32'd0;
            count     <= 32'd0;
            word_cnt  <= 32'd0;
            mem_valid <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (fifo_overflow) error <= 1'b1;

            case (state)
                ST_LEN: begin
                    if (pop) begin
                        byte_idx <= byte_idx + 2'd1;
                        asm_word <= next_word;
                        if (last_byte) begin
                            count <= next_word;
                            if (next_word == 32'd0) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else if (next_word > MAX_WORDS) begin
                                state <= ST_ERR;
                                error <= 1'b1;
                            end else begin
                                state <= ST_DATA;
                                busy  <= 1'b1;
                            end
                        end
                    end
                end

                ST_DATA: begin
                    if (pop) begin
                        byte_idx <= byte_idx + 2'd1;
                        asm_word <= next_word;
                        if (last_byte) begin
                            mem_wdata <= next_word;
                            mem_valid <= 1'b1;
                            state     <= ST_WRITE;
                        end
                    end
                end

                // Request stays frozen until accepted; the FIFO keeps absorbing bytes meanwhile.
                ST_WRITE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_addr  <= mem_addr + 32'd4;
                        word_cnt  <= word_cnt + 32'd1;
                        if (word_cnt + 32'd1 == count) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                ST_DONE: begin
                end

                ST_ERR: begin
                end

                default: begin
                    state <= ST_ERR;
                    error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Randomised scoreboard bench for uart_word_loader: expected writes are queued at stimulus time
// and a negedge monitor pops and compares them on every mem_valid/mem_ready handshake.
module tb_uart_word_loader;

    localparam logic [31:0] BASE  = 32'h8000_0100;
    localparam int          DEPTH = 8;
    localparam logic [31:0] MAXW  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words[16];
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          valid_cycles = 0;
    int          stall_cycles = 0;
    int          ready_mode = 0;
    int          stall_after = -1;
    int          stall_left = 0;
    int          low_run = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;

    uart_word_loader #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mem_ready driver: 0 always ready, 1 random (max 3 low in a row), 2 never ready.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 2) begin
            mem_ready = 1'b0;
        end else if (stall_left > 0 && mem_valid && hs_count == stall_after) begin
            mem_ready = 1'b0;
            stall_left--;
        end else if (ready_mode == 1) begin
            if (low_run >= 3 || $urandom_range(3) != 0) begin
                mem_ready = 1'b1;
                low_run = 0;
            end else begin
                mem_ready = 1'b0;
                low_run++;
            end
        end else begin
            mem_ready = 1'b1;
        end
    end

    // Monitor: hold-stability while stalled, and scoreboard compare on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check32("hold_valid", {31'd0, mem_valid}, 32'd1);
                check32("hold_addr", mem_addr, prev_addr);
                check32("hold_wdata", mem_wdata, prev_data);
            end
            if (mem_valid) valid_cycles++;
            if (mem_valid && !mem_ready) stall_cycles++;
            if (mem_valid && mem_ready) begin
                wr_t e;
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check32("write_addr", mem_addr, e.addr);
                    check32("write_data", mem_wdata, e.data);
                end
            end
            prev_stall = mem_valid && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; leaves rx_valid low.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] sh;
            sh = w >> (8 * k);
            send_byte(sh[7:0], $urandom_range(gmax, gmin));
        end
    endtask

    task automatic send_image(input int n, input int gmin, input int gmax);
        send_word(32'(n), gmin, gmax);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: BASE + 32'(4 * i), data: words[i]});
            send_word(words[i], gmin, gmax);
        end
    endtask

    task automatic do_reset();
        check32("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int n;
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        check32(name, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        while (!mem_valid && n < bound) begin
            tick();
            n++;
        end
        check32("wait_mem_valid", {31'd0, mem_valid}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int vc0;
        int sc0;
        logic [7:0]  stream[32];
        logic [31:0] held;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check32("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check32("rst_mem_addr", mem_addr, BASE);
        check32("rst_mem_wdata", mem_wdata, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_done", {31'd0, done}, 32'd0);
        check32("rst_error", {31'd0, error}, 32'd0);

        // Two-word directed image.
        hs0 = hs_count;
        send_word(32'd2, 1, 1);
        repeat (2) tick();
        check32("t1_busy_after_header", {31'd0, busy}, 32'd1);
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{addr: BASE + 32'(4 * i), data: words[i]});
            send_word(words[i], 1, 1);
        end
        wait_done(200, "t1_done");
        check32("t1_busy", {31'd0, busy}, 32'd0);
        check32("t1_error", {31'd0, error}, 32'd0);
        check32("t1_handshakes", 32'(hs_count - hs0), 32'd2);

        // Zero-length image.
        do_reset();
        vc0 = valid_cycles;
        send_word(32'd0, 0, 0);
        wait_done(2, "t2_done_within_2");
        repeat (4) tick();
        check32("t2_no_valid", 32'(valid_cycles - vc0), 32'd0);
        check32("t2_error", {31'd0, error}, 32'd0);

        // Three words, second write stalled for 20 cycles.
        do_reset();
        sc0 = stall_cycles;
        stall_after = hs_count + 1;
        stall_left = 20;
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        send_image(3, 1, 3);
        wait_done(500, "t3_done");
        check32("t3_stall_cycles", 32'(stall_cycles - sc0), 32'd20);
        check32("t3_error", {31'd0, error}, 32'd0);
        stall_left = 0;

        // Memory never ready: header + one word + DEPTH buffered bytes fit; the next one drops.
        do_reset();
        ready_mode = 2;
        tick();
        {stream[3], stream[2], stream[1], stream[0]} = 32'd5;
        for (int i = 4; i < 8 + DEPTH + 1; i++) stream[i] = 8'(8'h40 + i);
        for (int i = 0; i < 8 + DEPTH; i++) send_byte(stream[i], 0);
        check32("t4_no_error_before_drop", {31'd0, error}, 32'd0);
        send_byte(stream[8 + DEPTH], 0);
        check32("t4_error_on_drop", {31'd0, error}, 32'd1);
        held = {stream[7], stream[6], stream[5], stream[4]};
        check32("t4_valid_held", {31'd0, mem_valid}, 32'd1);
        check32("t4_addr_held", mem_addr, BASE);
        check32("t4_wdata_held", mem_wdata, held);

        // Oversized header goes to the error state and never writes.
        do_reset();
        ready_mode = 0;
        vc0 = valid_cycles;
        send_word(MAXW + 32'd1, 0, 1);
        repeat (3) tick();
        check32("t5_error", {31'd0, error}, 32'd1);
        check32("t5_busy", {31'd0, busy}, 32'd0);
        check32("t5_done", {31'd0, done}, 32'd0);
        send_word($urandom, 0, 1);
        repeat (6) tick();
        check32("t5_no_valid", 32'(valid_cycles - vc0), 32'd0);

        // Header exactly at the limit is accepted.
        do_reset();
        send_word(MAXW, 0, 1);
        repeat (3) tick();
        check32("t5b_busy_at_max", {31'd0, busy}, 32'd1);
        check32("t5b_error_at_max", {31'd0, error}, 32'd0);

        // Reset while a write is pending, then a fresh one-word image.
        do_reset();
        ready_mode = 2;
        send_word(32'd1, 1, 1);
        send_word(32'hCAFE_F00D, 1, 1);
        wait_valid(100);
        rst = 1'b1;
        tick();
        check32("t6_valid_dropped", {31'd0, mem_valid}, 32'd0);
        rst = 1'b0;
        ready_mode = 0;
        tick();
        words[0] = 32'h0BAD_1DEA;
        send_image(1, 1, 2);
        wait_done(200, "t6_done");
        check32("t6_error", {31'd0, error}, 32'd0);

        // Random images with random memory stalls.
        for (int r = 0; r < 5; r++) begin
            int n;
            do_reset();
            ready_mode = 1;
            hs0 = hs_count;
            n = $urandom_range(8, 1);
            for (int i = 0; i < n; i++) words[i] = $urandom;
            send_image(n, 1, 3);
            wait_done(2000, "rand_done");
            check32("rand_error", {31'd0, error}, 32'd0);
            check32("rand_handshakes", 32'(hs_count - hs0), 32'(n));
            ready_mode = 0;
        end

        repeat (4) tick();
        check32("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
